floor_gen: RTL

Platform generator feeding `slime_move`. Maintains eight platform slots and drives `floor_pos_x*/floor_pos_y*/enable`. When the slime lands above mid-screen (`hit_ceiling`), the platforms scroll down following the jump velocity profile, so the camera appears to follow the slime. Platforms that pass the bottom edge are retired, and new ones are spawned at the top at x positions from an LFSR.

---
 rtl/floor_pkg.sv | 48 ++++
 rtl/floor_gen_lfsr10.sv | 32 +++
 rtl/floor_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/floor_pkg.sv
// floor_pkg: shared constants and helpers for the platform generator.
// Screen geometry, spawn spacing, reset layout and LFSR defaults.
package floor_pkg;

    localparam int N_SLOTS  = 8;
    localparam int SPACING  = 60;
    localparam int FLOOR_W  = 40;
    localparam int X_LIMIT  = 620;
    localparam int RESET_Y0 = 380;

    localparam logic [9:0] SCREEN_H  = 10'd480;
    localparam logic [9:0] X_SPAN    = 10'(X_LIMIT - FLOOR_W);
    localparam logic [9:0] X_FOLD    = 10'd444;
    localparam logic [9:0] LFSR_SEED = 10'h1A5;
    localparam logic [9:0] RESET_X   = 10'd300;

    typedef logic [N_SLOTS-1:0]       slot_mask_t;
    typedef logic [N_SLOTS-1:0][9:0]  pos_arr_t;
    typedef logic [7:0]               acc_t;

    // The topmost reset platform sits RESET_Y0 - SPACING*(N_SLOTS-2) rows
    // below a virtual spawn at y = 0, so the counter starts that far along.
    localparam acc_t ACC_RESET = acc_t'(RESET_Y0 - SPACING * (N_SLOTS - 2));
    localparam acc_t ACC_LAST  = acc_t'(SPACING - 1);

    // Fold a 10-bit random value into the legal left-edge range 0..579.
    function automatic logic [9:0] xmap(input logic [9:0] v);
        return (v < X_SPAN) ? v : v - X_FOLD;
    endfunction

    // Mirror of the slime ascent profile: denser steps early in the jump.
    function automatic logic step_due(input logic [8:0] tg);
        if (tg == 9'd0) begin
            return 1'b0;
        end else if (tg < 9'd80) begin
            return 1'b1;
        end else if (tg < 9'd160) begin
            return tg[0] == 1'b0;
        end else if (tg < 9'd240) begin
            return tg[1:0] == 2'b00;
        end else if (tg < 9'd320) begin
            return tg[2:0] == 3'b000;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/floor_gen_lfsr10.sv
// lfsr10: free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1.
// Maximal length, so a non-zero seed never reaches the all-zero state.
module lfsr10
    import floor_pkg::*;
#(
    parameter logic [9:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] state
);

    logic [9:0] state_q;
    logic [9:0] state_d;

    // Shift left, feeding back the xor of bits 10 and 7.
    always_comb begin
        state_d = {state_q[8:0], state_q[9] ^ state_q[6]};
    end

    // Advance on every clock; reset loads the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/floor_gen.sv
// floor_gen: eight platform slots that scroll with the slime's ascent.
// Scroll, retire at the bottom, and spawn at the top from the LFSR.
module floor_gen
    import floor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_vga,
    input  logic       hit_ceiling,
    input  logic [8:0] time_gap,
    input  logic       slime_die,
    output logic [9:0] floor_pos_x0,
    output logic [9:0] floor_pos_x1,
    output logic [9:0] floor_pos_x2,
    output logic [9:0] floor_pos_x3,
    output logic [9:0] floor_pos_x4,
    output logic [9:0] floor_pos_x5,
    output logic [9:0] floor_pos_x6,
    output logic [9:0] floor_pos_x7,
    output logic [9:0] floor_pos_y0,
    output logic [9:0] floor_pos_y1,
    output logic [9:0] floor_pos_y2,
    output logic [9:0] floor_pos_y3,
    output logic [9:0] floor_pos_y4,
    output logic [9:0] floor_pos_y5,
    output logic [9:0] floor_pos_y6,
    output logic [9:0] floor_pos_y7,
    output logic [7:0] enable,
    output logic       spawn_miss
);

    pos_arr_t   x_q, x_d;
    pos_arr_t   y_q, y_d;
    slot_mask_t en_q, en_d;
    acc_t       acc_q, acc_d;
    logic       miss_q, miss_d;

    slot_mask_t free;
    slot_mask_t pick;
    logic       do_step;
    logic [9:0] lfsr;

    lfsr10 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign do_step = clk_vga & hit_ceiling & ~slime_die & step_due(time_gap);

    // One step: scroll live slots, retire at the bottom, then maybe spawn.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        en_d   = en_q;
        acc_d  = acc_q;
        miss_d = miss_q;
        free   = '0;
        pick   = '0;
        if (do_step) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (en_q[i]) begin
                    y_d[i] = y_q[i] + 10'd1;
                    if (y_d[i] >= SCREEN_H) begin
                        en_d[i] = 1'b0;
                        y_d[i]  = '0;
                    end
                end
            end
            // Lowest free slot after retirement, so a freed slot is reused.
            free = ~en_d;
            pick = free & (~free + slot_mask_t'(1));
            if (acc_q == ACC_LAST) begin
                acc_d = '0;
                if (free == '0) begin
                    miss_d = 1'b1;
                end
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (pick[i]) begin
                        en_d[i] = 1'b1;
                        y_d[i]  = '0;
                        x_d[i]  = xmap(lfsr);
                    end
                end
            end else begin
                acc_d = acc_q + acc_t'(1);
            end
        end
    end

    // Slot registers; reset restores the staircase start layout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (i < N_SLOTS - 1) begin
                    en_q[i] <= 1'b1;
                    x_q[i]  <= RESET_X;
                    y_q[i]  <= 10'(RESET_Y0 - SPACING * i);
                end else begin
                    en_q[i] <= 1'b0;
                    x_q[i]  <= '0;
                    y_q[i]  <= '0;
                end
            end
            acc_q  <= ACC_RESET;
            miss_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            en_q   <= en_d;
            acc_q  <= acc_d;
            miss_q <= miss_d;
        end
    end

    assign floor_pos_x0 = x_q[0];
    assign floor_pos_x1 = x_q[1];
    assign floor_pos_x2 = x_q[2];
    assign floor_pos_x3 = x_q[3];
    assign floor_pos_x4 = x_q[4];
    assign floor_pos_x5 = x_q[5];
    assign floor_pos_x6 = x_q[6];
    assign floor_pos_x7 = x_q[7];
    assign floor_pos_y0 = y_q[0];
    assign floor_pos_y1 = y_q[1];
    assign floor_pos_y2 = y_q[2];
    assign floor_pos_y3 = y_q[3];
    assign floor_pos_y4 = y_q[4];
    assign floor_pos_y5 = y_q[5];
    assign floor_pos_y6 = y_q[6];
    assign floor_pos_y7 = y_q[7];
    assign enable       = en_q;
    assign spawn_miss   = miss_q;

endmodule
